// File: rtl/booth_datapath.sv
// booth_datapath
// Operand/accumulator datapath of a radix-2 Booth multiplier. Holds the
// multiplicand M and the {HQ,LQ,Q_1} shift chain, executes the control
// FSM's load / add-subtract / shift strobes, feeds Q_0, Q_1 and Z back,
// and presents the finished signed product on a valid/ready port.
//
// Optional feature: define BOOTH_OVERRUN_EN to add the sticky
// product_overrun flag (set when an unconsumed product is overwritten).

module booth_datapath #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   input  logic                 load_A,
   input  logic                 load_B,
   input  logic                 load_add,
   input  logic                 add_sub,
   input  logic                 shift_HQ_LQ_Q_1,
   output logic                 Q_0,
   output logic                 Q_1,
   output logic                 Z,
   output logic [2*WIDTH-1:0]   product,
   output logic                 product_valid,
`ifdef BOOTH_OVERRUN_EN
   output logic                 product_overrun,
`endif
   input  logic                 product_ready
);

   localparam int CW = $clog2(WIDTH + 1);

   // HQ and M carry one guard bit so that M = -2^(WIDTH-1) cannot overflow
   logic [WIDTH:0]   m;
   logic [WIDTH:0]   hq;
   logic [WIDTH-1:0] lq;
   logic             q1;
   logic [CW-1:0]    count;

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   hq_pre;
   logic [WIDTH:0]   hq_next;
   logic [WIDTH-1:0] lq_next;
   logic             q1_next;
   logic             loading;
   logic             do_shift;
   logic             completion;

   // Add/subtract first, then shift the sum; loads override everything else
   always_comb begin
      loading    = load_A | load_B;
      sum        = add_sub ? (hq + m) : (hq - m);
      hq_pre     = load_add ? sum : hq;
      do_shift   = shift_HQ_LQ_Q_1 && !loading && (count != '0);
      hq_next    = {hq_pre[WIDTH], hq_pre[WIDTH:1]};
      lq_next    = {hq_pre[0], lq[WIDTH-1:1]};
      q1_next    = lq[0];
      completion = do_shift && (count == CW'(1));
   end

   // Operand and shift-chain registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m     <= '0;
         hq    <= '0;
         lq    <= '0;
         q1    <= 1'b0;
         count <= '0;
      end else if (loading) begin
         if (load_A) begin
            m     <= {A[WIDTH-1], A};
            hq    <= '0;
            count <= CW'(WIDTH);
         end
         if (load_B) begin
            lq <= B;
            q1 <= 1'b0;
         end
      end else if (do_shift) begin
         hq    <= hq_next;
         lq    <= lq_next;
         q1    <= q1_next;
         count <= count - 1'b1;
      end else if (load_add) begin
         hq <= sum;
      end
   end

   // Result register and valid flag; a fresh completion always wins over a consume
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         product       <= '0;
         product_valid <= 1'b0;
      end else if (completion) begin
         product       <= {hq_next[WIDTH-1:0], lq_next};
         product_valid <= 1'b1;
      end else if (product_valid && product_ready) begin
         product_valid <= 1'b0;
      end
   end

`ifdef BOOTH_OVERRUN_EN
   // Sticky record of a result lost to overwrite under backpressure
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         product_overrun <= 1'b0;
      end else if (completion && product_valid && !product_ready) begin
         product_overrun <= 1'b1;
      end
   end
`endif

   assign Q_0 = lq[0];
   assign Q_1 = q1;
   assign Z   = (count == '0);

endmodule
